// File: rtl/count_modn.sv
// Modulo-MOD up/down counter with synchronous clear and load, registered
// wrap pulses, a combinational terminal count for cascading and a sticky bad-load flag.
module count_modn #(
    parameter int WIDTH = 4,
    parameter int MOD   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             co,
    output logic             bo,
    output logic             tc,
    output logic             load_err
);

    // The modulus may equal 2**WIDTH, so the legality compare needs one extra bit.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] r_count;
    logic             r_co;
    logic             r_bo;
    logic             r_load_err;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_co_nxt;
    logic             w_bo_nxt;
    logic             w_load_err_nxt;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_load_ok;

    assign w_at_max  = (r_count == MAX_VAL);
    assign w_at_zero = (r_count == '0);
    assign w_load_ok = ({1'b0, load_val} < MOD_EXT);

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_count_nxt    = r_count;
        w_co_nxt       = 1'b0;
        w_bo_nxt       = 1'b0;
        w_load_err_nxt = r_load_err;
        if (clr) begin
            w_count_nxt    = '0;
            w_load_err_nxt = 1'b0;
        end else if (load) begin
            if (w_load_ok) begin
                w_count_nxt = load_val;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (en) begin
            if (dir) begin
                if (w_at_max) begin
                    w_count_nxt = '0;
                    w_co_nxt    = 1'b1;
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    w_count_nxt = MAX_VAL;
                    w_bo_nxt    = 1'b1;
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_co       <= 1'b0;
            r_bo       <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_co       <= w_co_nxt;
            r_bo       <= w_bo_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    // Zero-latency wrap look-ahead; drives the next stage's en directly.
    assign tc = en & ~clr & ~load & ((dir & w_at_max) | (~dir & w_at_zero));

    assign count    = r_count;
    assign co       = r_co;
    assign bo       = r_bo;
    assign load_err = r_load_err;

endmodule
